// File: rtl/gmsk_trace_pkg.sv
// Shared constants and packed-entry layout for the GMSK-V1 register-file trace monitor.
// Entry layout, LSB first: mask | addresses | data | pc | timestamp.
package gmsk_trace_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  function automatic int entry_w(input int num_ports, input int ts_w);
    return num_ports * (1 + REG_AW + XLEN) + XLEN + ts_w;
  endfunction

  function automatic int off_addr(input int num_ports);
    return num_ports;
  endfunction

  function automatic int off_data(input int num_ports);
    return num_ports * (1 + REG_AW);
  endfunction

  function automatic int off_pc(input int num_ports);
    return num_ports * (1 + REG_AW + XLEN);
  endfunction

  function automatic int off_time(input int num_ports);
    return num_ports * (1 + REG_AW + XLEN) + XLEN;
  endfunction

endpackage

// File: rtl/gmsk_sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push into a full FIFO is accepted
// only when a pop happens on the same edge; clear_i and rst both empty it.
module gmsk_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o && !clear_i;
  assign push_ok = push_i && (!full_o || pop_ok) && !clear_i;

  // Storage is not reset; stale words are unreachable once the pointers are.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gmsk_rf_trace_monitor.sv
// Register-file writeback tracer: packs each cycle's qualifying writes into a
// timestamped entry, buffers them in a FWFT FIFO and watches the PC for stalls.
module gmsk_rf_trace_monitor
  import gmsk_trace_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int DEPTH       = 16,
  parameter int TS_W        = 16,
  parameter int STALL_LIMIT = 64,
  parameter int FILTER_X0   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable_i,
  input  logic                        clear_i,
  input  logic [XLEN-1:0]             pc_i,
  input  logic [NUM_PORTS-1:0]        we_i,
  input  logic [REG_AW*NUM_PORTS-1:0] waddr_i,
  input  logic [XLEN*NUM_PORTS-1:0]   wdata_i,
  output logic                        trc_valid_o,
  input  logic                        trc_ready_i,
  output logic [NUM_PORTS-1:0]        trc_mask_o,
  output logic [REG_AW*NUM_PORTS-1:0] trc_addr_o,
  output logic [XLEN*NUM_PORTS-1:0]   trc_data_o,
  output logic [XLEN-1:0]             trc_pc_o,
  output logic [TS_W-1:0]             trc_time_o,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic [15:0]                 drop_cnt_o,
  output logic                        overflow_o,
  output logic                        stall_o
);

  localparam int EW       = entry_w(NUM_PORTS, TS_W);
  localparam int OFF_ADDR = off_addr(NUM_PORTS);
  localparam int OFF_DATA = off_data(NUM_PORTS);
  localparam int OFF_PC   = off_pc(NUM_PORTS);
  localparam int OFF_TIME = off_time(NUM_PORTS);
  localparam int SC_W     = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_LIMIT);

  logic [NUM_PORTS-1:0] mask;
  logic                 push, drop;
  logic [EW-1:0]        entry_in, head;
  logic                 fifo_full, fifo_empty;

  logic [TS_W-1:0]      ts_q;
  logic [XLEN-1:0]      pc_prev_q;
  logic [SC_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                 stall_q, stall_d;
  logic [15:0]          drop_cnt_q;
  logic                 overflow_q;

  always_comb begin
    mask = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      mask[k] = we_i[k] && !((FILTER_X0 != 0) && (waddr_i[k*REG_AW +: REG_AW] == '0));
    end
  end

  assign push     = enable_i && (|mask) && !clear_i;
  assign entry_in = {ts_q, pc_i, wdata_i, waddr_i, mask};
  // A full FIFO only loses the entry when the consumer is not draining this cycle.
  assign drop     = push && fifo_full && !trc_ready_i;

  // Trace handshake: a pop happens on any edge where trc_valid_o && trc_ready_i;
  // while trc_valid_o && !trc_ready_i every trc_* output holds its value.
  gmsk_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .push_i  (push),
    .wdata_i (entry_in),
    .pop_i   (trc_ready_i),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  // Head fields are forced to zero when empty so idle outputs are deterministic.
  assign trc_valid_o = !fifo_empty;
  assign trc_mask_o  = trc_valid_o ? head[0 +: NUM_PORTS]               : '0;
  assign trc_addr_o  = trc_valid_o ? head[OFF_ADDR +: REG_AW*NUM_PORTS] : '0;
  assign trc_data_o  = trc_valid_o ? head[OFF_DATA +: XLEN*NUM_PORTS]   : '0;
  assign trc_pc_o    = trc_valid_o ? head[OFF_PC +: XLEN]               : '0;
  assign trc_time_o  = trc_valid_o ? head[OFF_TIME +: TS_W]             : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      overflow_q <= 1'b1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_i != pc_prev_q) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    stall_d = (stall_cnt_d == STALL_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_prev_q   <= '0;
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      pc_prev_q   <= pc_i;
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: tb/tb_gmsk_rf_trace_monitor.sv
// Directed bench for gmsk_rf_trace_monitor: a vector table for capture/filter/pop
// behaviour plus hand-written overflow, backpressure, watchdog and reset sequences.
module tb_gmsk_rf_trace_monitor;

  localparam int NP    = 2;
  localparam int DEPTH = 16;
  localparam int TS_W  = 16;
  localparam int SL    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [1:0]  we_i = '0;
  logic [9:0]  waddr_i = '0;
  logic [63:0] wdata_i = '0;
  logic        trc_ready_i = 1'b0;

  logic        trc_valid_o;
  logic [1:0]  trc_mask_o;
  logic [9:0]  trc_addr_o;
  logic [63:0] trc_data_o;
  logic [31:0] trc_pc_o;
  logic [15:0] trc_time_o;
  logic [4:0]  level_o;
  logic [15:0] drop_cnt_o;
  logic        overflow_o;
  logic        stall_o;

  gmsk_rf_trace_monitor #(
    .NUM_PORTS   (NP),
    .DEPTH       (DEPTH),
    .TS_W        (TS_W),
    .STALL_LIMIT (SL),
    .FILTER_X0   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable_i),
    .clear_i     (clear_i),
    .pc_i        (pc_i),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .trc_valid_o (trc_valid_o),
    .trc_ready_i (trc_ready_i),
    .trc_mask_o  (trc_mask_o),
    .trc_addr_o  (trc_addr_o),
    .trc_data_o  (trc_data_o),
    .trc_pc_o    (trc_pc_o),
    .trc_time_o  (trc_time_o),
    .level_o     (level_o),
    .drop_cnt_o  (drop_cnt_o),
    .overflow_o  (overflow_o),
    .stall_o     (stall_o)
  );

  // Clock / reset and a bench-side timestamp model.
  always #5 clk = ~clk;

  logic [15:0] cyc;
  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 16'd1;
  end

  typedef struct {
    logic        en;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [31:0] pc;
    logic        rdy;
    logic        x_valid;
    logic [1:0]  x_mask;
    logic [9:0]  x_addr;
    logic [63:0] x_data;
    logic [31:0] x_pc;
    logic [15:0] x_time;
    logic [4:0]  x_level;
  } vec_t;

  vec_t        vecs [11];
  logic [15:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] t0, t1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    enable_i    = 1'b0;
    clear_i     = 1'b0;
    we_i        = '0;
    waddr_i     = '0;
    wdata_i     = '0;
    trc_ready_i = 1'b0;
  endtask

  task automatic drive_push(input logic [4:0] a0, input logic [31:0] d0, input logic rdy);
    enable_i    = 1'b1;
    we_i        = 2'b01;
    waddr_i     = {5'd0, a0};
    wdata_i     = {32'd0, d0};
    trc_ready_i = rdy;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'b01, {5'd9, 5'd5}, {32'h11111111, 32'hDEADBEEF}, 32'h80, 1'b0,
                 1'b1, 2'b01, {5'd9, 5'd5}, {32'h11111111, 32'hDEADBEEF}, 32'h80, 16'd3, 5'd1};
    vecs[1]  = '{1'b1, 2'b11, {5'd7, 5'd0}, {32'hB, 32'hA}, 32'h84, 1'b0,
                 1'b1, 2'b01, {5'd9, 5'd5}, {32'h11111111, 32'hDEADBEEF}, 32'h80, 16'd3, 5'd2};
    vecs[2]  = '{1'b1, 2'b01, {5'd7, 5'd0}, {32'hD, 32'hC}, 32'h88, 1'b0,
                 1'b1, 2'b01, {5'd9, 5'd5}, {32'h11111111, 32'hDEADBEEF}, 32'h80, 16'd3, 5'd2};
    vecs[3]  = '{1'b0, 2'b11, {5'd4, 5'd3}, {32'hF, 32'hE}, 32'h8C, 1'b0,
                 1'b1, 2'b01, {5'd9, 5'd5}, {32'h11111111, 32'hDEADBEEF}, 32'h80, 16'd3, 5'd2};
    vecs[4]  = '{1'b1, 2'b00, {5'd2, 5'd1}, 64'd0, 32'h90, 1'b0,
                 1'b1, 2'b01, {5'd9, 5'd5}, {32'h11111111, 32'hDEADBEEF}, 32'h80, 16'd3, 5'd2};
    vecs[5]  = '{1'b0, 2'b00, {5'd2, 5'd1}, 64'd0, 32'h94, 1'b1,
                 1'b1, 2'b10, {5'd7, 5'd0}, {32'hB, 32'hA}, 32'h84, 16'd4, 5'd1};
    vecs[6]  = '{1'b1, 2'b10, {5'd12, 5'd1}, {32'h22, 32'h21}, 32'h98, 1'b1,
                 1'b1, 2'b10, {5'd12, 5'd1}, {32'h22, 32'h21}, 32'h98, 16'd9, 5'd1};
    vecs[7]  = '{1'b1, 2'b11, {5'd6, 5'd6}, {32'h2, 32'h1}, 32'h9C, 1'b0,
                 1'b1, 2'b10, {5'd12, 5'd1}, {32'h22, 32'h21}, 32'h98, 16'd9, 5'd2};
    vecs[8]  = '{1'b0, 2'b00, {5'd6, 5'd6}, 64'd0, 32'hA0, 1'b1,
                 1'b1, 2'b11, {5'd6, 5'd6}, {32'h2, 32'h1}, 32'h9C, 16'd10, 5'd1};
    vecs[9]  = '{1'b0, 2'b00, 10'd0, 64'd0, 32'hA4, 1'b1,
                 1'b0, 2'b00, 10'd0, 64'd0, 32'h0, 16'd0, 5'd0};
    vecs[10] = '{1'b0, 2'b11, {5'd3, 5'd3}, 64'd0, 32'hA8, 1'b1,
                 1'b0, 2'b00, 10'd0, 64'd0, 32'h0, 16'd0, 5'd0};

    // Reset state
    @(negedge clk);
    tick();
    chk("rst valid", trc_valid_o, 0);
    chk("rst level", level_o, 0);
    chk("rst drop", drop_cnt_o, 0);
    chk("rst ovf", overflow_o, 0);
    chk("rst stall", stall_o, 0);
    chk("rst time", trc_time_o, 0);
    chk("rst data", trc_data_o, 0);
    rst = 1'b0;
    tick();
    tick();
    tick();

    // Vector table: capture, x0 filter, enable gating, pops, duplicates, empty pop
    for (int i = 0; i < 11; i++) begin
      enable_i    = vecs[i].en;
      we_i        = vecs[i].we;
      waddr_i     = vecs[i].waddr;
      wdata_i     = vecs[i].wdata;
      pc_i        = vecs[i].pc;
      trc_ready_i = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d valid", i), trc_valid_o, vecs[i].x_valid);
      chk($sformatf("v%0d mask", i),  trc_mask_o,  vecs[i].x_mask);
      chk($sformatf("v%0d addr", i),  trc_addr_o,  vecs[i].x_addr);
      chk($sformatf("v%0d data", i),  trc_data_o,  vecs[i].x_data);
      chk($sformatf("v%0d pc", i),    trc_pc_o,    vecs[i].x_pc);
      chk($sformatf("v%0d time", i),  trc_time_o,  vecs[i].x_time);
      chk($sformatf("v%0d level", i), level_o,     vecs[i].x_level);
    end
    drive_idle();

    // Overflow: 20 pushes with no consumer
    for (int i = 0; i < 20; i++) begin
      drive_push(5'(i + 1), 32'(i), 1'b0);
      pc_i = 32'h200 + 32'(4 * i);
      if (i < DEPTH) exp_q.push_back(cyc);
      tick();
    end
    drive_idle();
    chk("ovf level", level_o, 16);
    chk("ovf drop", drop_cnt_o, 4);
    chk("ovf flag", overflow_o, 1);
    chk("ovf head time", trc_time_o, exp_q[0]);
    chk("ovf head addr", trc_addr_o, {5'd0, 5'd1});

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      drive_push(5'd5, 32'hA0 + 32'(i), 1'b1);
      chk($sformatf("pp head time %0d", i), trc_time_o, exp_q[0]);
      void'(exp_q.pop_front());
      exp_q.push_back(cyc);
      tick();
    end
    drive_idle();
    chk("pp level", level_o, 16);
    chk("pp drop", drop_cnt_o, 4);

    // Drain in order
    trc_ready_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain valid %0d", i), trc_valid_o, 1);
      chk($sformatf("drain time %0d", i), trc_time_o, exp_q.pop_front());
      tick();
    end
    chk("drain empty", trc_valid_o, 0);
    chk("drain drop kept", drop_cnt_o, 4);

    // Clear wins over a simultaneous push
    drive_push(5'd8, 32'h77, 1'b1);
    clear_i = 1'b1;
    tick();
    drive_idle();
    chk("clr level", level_o, 0);
    chk("clr valid", trc_valid_o, 0);
    chk("clr drop", drop_cnt_o, 0);
    chk("clr ovf", overflow_o, 0);

    // Backpressure holds the head stable
    drive_push(5'd9, 32'h1234, 1'b0);
    t0 = cyc;
    tick();
    drive_push(5'd10, 32'h5678, 1'b0);
    t1 = cyc;
    tick();
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp time %0d", i), trc_time_o, t0);
      chk($sformatf("bp data %0d", i), trc_data_o, 64'h1234);
      chk($sformatf("bp addr %0d", i), trc_addr_o, {5'd0, 5'd9});
      chk($sformatf("bp level %0d", i), level_o, 2);
    end
    trc_ready_i = 1'b1;
    tick();
    chk("bp next time", trc_time_o, t1);
    chk("bp next data", trc_data_o, 64'h5678);
    chk("bp next level", level_o, 1);
    tick();
    chk("bp drained", trc_valid_o, 0);
    trc_ready_i = 1'b0;

    // Watchdog: stall rises exactly SL edges after the PC change edge
    pc_i = 32'h100;
    tick();
    chk("wd change", stall_o, 0);
    for (int i = 1; i < SL; i++) begin
      tick();
      chk($sformatf("wd hold %0d", i), stall_o, 0);
    end
    tick();
    chk("wd stall", stall_o, 1);
    tick();
    chk("wd stall sat", stall_o, 1);
    pc_i = 32'h104;
    tick();
    chk("wd cleared", stall_o, 0);

    // Reset mid-stall with a non-empty FIFO
    drive_push(5'd11, 32'hCAFE, 1'b0);
    tick();
    drive_idle();
    for (int i = 1; i < SL; i++) tick();
    chk("pre-rst stall", stall_o, 1);
    chk("pre-rst level", level_o, 1);
    rst = 1'b1;
    tick();
    chk("mid-rst stall", stall_o, 0);
    chk("mid-rst valid", trc_valid_o, 0);
    chk("mid-rst level", level_o, 0);
    chk("mid-rst time", trc_time_o, 0);
    rst = 1'b0;
    tick();
    drive_push(5'd12, 32'hBEEF, 1'b0);
    t0 = cyc;
    tick();
    drive_idle();
    chk("post-rst time", trc_time_o, t0);
    chk("post-rst time val", trc_time_o, 1);
    chk("post-rst level", level_o, 1);
    chk("post-rst stall", stall_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gmsk_rf_trace_monitor.md
Name: gmsk_rf_trace_monitor

Overview:
- Synthesizable register-file writeback tracer and liveness watchdog for the GMSK-V1 SoC.
- Taps NUM_PORTS register-file write ports and the core PC.
- Packs each cycle's qualifying writes into one timestamped trace entry and buffers entries in a FIFO that drains over a valid/ready interface.
- Flags PC stalls. It replaces simulation-only hierarchical peeking with an on-chip, parametrised monitor.

Parameters:
- NUM_PORTS, 2: number of register-file write ports monitored (1..4).
- DEPTH, 16: trace FIFO entries; power of two, at least 2.
- TS_W, 16: timestamp counter width.
- STALL_LIMIT, 64: consecutive cycles of unchanged PC before stall_o asserts; at least 1.
- FILTER_X0, 1: when 1, writes to x0 are ignored.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: synchronous, active-high reset.
- enable_i, in, 1: capture enable. The watchdog and timestamp run regardless.
- clear_i, in, 1: synchronous flush of FIFO, drop_cnt_o and overflow_o.
- pc_i, in, 32: core current PC.
- we_i, in, NUM_PORTS: per-port write enable.
- waddr_i, in, 5*NUM_PORTS: per-port write address; port k uses bits [5k+4:5k].
- wdata_i, in, 32*NUM_PORTS: per-port write data; port k uses bits [32k+31:32k].
- trc_valid_o, out, 1: FIFO head valid.
- trc_ready_i, in, 1: consumer accepts head.
- trc_mask_o, out, NUM_PORTS: qualifying write mask of head entry.
- trc_addr_o, out, 5*NUM_PORTS: head addresses.
- trc_data_o, out, 32*NUM_PORTS: head data.
- trc_pc_o, out, 32: PC sampled with head entry.
- trc_time_o, out, TS_W: timestamp of head entry.
- level_o, out, $clog2(DEPTH)+1: current occupancy.
- drop_cnt_o, out, 16: entries dropped while full; saturates at 0xFFFF.
- overflow_o, out, 1: sticky; set on any drop.
- stall_o, out, 1: PC unchanged for at least STALL_LIMIT cycles.

Behaviour:
- Reset values: all outputs are 0. FIFO is empty, timestamp is 0, stall counter is 0, and pc_prev is 0.
- Timestamp: free-running counter, incremented every cycle, wraps modulo 2^TS_W. An entry captures the counter value of its capture cycle.
- Qualifying mask: mask[k] = we_i[k] && !(FILTER_X0 && waddr_k == 0).
- Push condition: enable_i && |mask && !clear_i. A push writes one entry containing the mask, all addresses, all data, pc_i and the timestamp. Unmasked lanes carry raw input values; consumers ignore them.
- Same-cycle duplicate addresses on different ports are both recorded. No arbitration is performed.
- FIFO is first-word-fall-through. A pushed entry is visible on trc_* one cycle after the capture edge. There is no same-cycle bypass.
- Handshake: pop happens when trc_valid_o && trc_ready_i. trc_* stay stable while valid && !ready.
- Full with push and no pop: the entry is dropped, drop_cnt_o increments (saturating) and overflow_o is set.
- Full with push and pop in the same cycle: both succeed and the level is unchanged. No drop occurs.
- Empty with trc_ready_i high: no effect.
- clear_i: on the next edge, level = 0, trc_valid_o = 0, drop_cnt_o = 0 and overflow_o = 0.
  - clear_i takes priority over a simultaneous push or pop.
  - Timestamp and watchdog are unaffected by clear_i.
- Watchdog:
  - If pc_i != pc_prev, the counter is set to 0 and stall_o is cleared on that edge.
  - Otherwise the counter increments, saturating at STALL_LIMIT.
  - stall_o = (counter == STALL_LIMIT), registered.
  - pc_prev <= pc_i every cycle.
- Reset mid-operation: the FIFO contents are discarded and all state returns to reset values on that edge. Nothing is preserved.

Decomposition:
- Package gmsk_trace_pkg:
  - REG_AW = 5, XLEN = 32.
  - Entry-width function: NUM_PORTS*(1+5+32) + 32 + TS_W.
  - Packed entry field offsets.
- Sub-module gmsk_sync_fifo (WIDTH, DEPTH): FWFT, with push/pop/full/empty/level and sync active-high rst and clear.
- Top level: mask qualification, entry packing/unpacking, drop counter, timestamp and watchdog.

Test Plan:
- Capture: after reset, enable_i=1, drive we_i=2'b01, waddr0=5, wdata0=0xDEADBEEF, pc_i=0x80 at timestamp 3. Next cycle, require trc_valid_o=1, mask=01, addr0=5, data0=0xDEADBEEF, pc=0x80, time=3, level_o=1.
- x0 filter: we_i=2'b11 with waddr0=0 and waddr1=7 -> mask=10. Then we_i=2'b01 with waddr0=0 -> no push; level_o is unchanged.
- Overflow: with DEPTH=16 and trc_ready_i=0, drive 20 consecutive pushes -> level_o=16, drop_cnt_o=4, overflow_o=1. Then pulse clear_i for one cycle -> level_o=0, drop_cnt_o=0, overflow_o=0.
- Full with simultaneous push and pop: with the FIFO full and trc_ready_i=1 while pushing -> no drop; level_o stays 16; entries emerge in order, matching their timestamps.
- Backpressure: with head valid, hold trc_ready_i=0 for 5 cycles -> trc_* are unchanged. Then raise ready -> the next entry appears the following cycle.
- Watchdog: hold pc_i=0x100 -> stall_o rises exactly STALL_LIMIT=64 cycles after the last change. Then change pc_i to 0x104 -> stall_o=0 after that edge. Assert rst mid-stall -> stall_o=0 and FIFO empty on that edge.
